pipeline_hazard_ctrl: RTL

- Hazard/stall controller that sequences the ID/EX pipeline register and its neighbouring stage registers.
- Detects load-use hazards between ID and EX and inserts a single bubble.
- Squashes wrong-path instructions after a taken branch resolved in EX.
- Freezes the whole pipeline while a multi-cycle data memory is busy, and watchdogs that wait.
- Drives the enable and bubble/flush controls of the PC, IF/ID, ID/EX and EX/MEM registers.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 17 +
 rtl/pipeline_hazard_ctrl_load_use_detect.sv | 13 +
 rtl/pipeline_hazard_ctrl.sv | 94 +++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// pipeline_hazard_ctrl_pkg: shared state encoding, register index constants and control bundle
package pipeline_hazard_ctrl_pkg;
  typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, FLUSH = 2'd2} hazard_state_t;
  localparam logic [4:0] XZR_IDX = 5'd31;
  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_write;
    logic id_ex_bubble;
    logic ex_mem_write;
  } hazard_ctrl_t;
  localparam hazard_ctrl_t CTRL_NORMAL = hazard_ctrl_t'(6'b110101);
  localparam hazard_ctrl_t CTRL_FREEZE = hazard_ctrl_t'(6'b000000);
  localparam hazard_ctrl_t CTRL_SQUASH = hazard_ctrl_t'(6'b111111);
  localparam hazard_ctrl_t CTRL_STALL  = hazard_ctrl_t'(6'b000111);
endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// load_use_detect: flags an ID operand that depends on a load still in EX (XZR never hazards)
module load_use_detect import pipeline_hazard_ctrl_pkg::*; (
  input  logic       ex_mem_read_i,
  input  logic [4:0] ex_rd_i,
  input  logic [4:0] id_rn_i,
  input  logic [4:0] id_rm_i,
  input  logic       id_uses_rn_i,
  input  logic       id_uses_rm_i,
  output logic       load_use_o
);
  assign load_use_o = ex_mem_read_i && ex_rd_i != XZR_IDX &&
                      ((id_uses_rn_i && id_rn_i == ex_rd_i) || (id_uses_rm_i && id_rm_i == ex_rd_i));
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/squash/freeze sequencing for the PC, IF/ID, ID/EX and EX/MEM registers.
// HAZARD_PERF_EN adds saturating load-use bubble and taken-branch counters.
module pipeline_hazard_ctrl import pipeline_hazard_ctrl_pkg::*; #(
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_Rd,
  input  logic [4:0]  id_Rn,
  input  logic [4:0]  id_Rm,
  input  logic        id_uses_Rn,
  input  logic        id_uses_Rm,
  input  logic        branch_taken,
  input  logic        mem_busy,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        if_id_flush,
  output logic        id_ex_write,
  output logic        id_ex_bubble,
  output logic        ex_mem_write,
  output logic        mem_timeout,
`ifdef HAZARD_PERF_EN
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt,
`endif
  output logic [1:0]  state_o
);
  hazard_state_t st_q, st_d;
  logic [3:0]  fl_q, fl_d;
  logic [15:0] wt_q, wt_d;
  logic        to_q, to_d, load_use, stall_ev, br_ev;
  hazard_ctrl_t ctrl;
  load_use_detect u_lud (
    .ex_mem_read_i(ex_mem_read), .ex_rd_i(ex_Rd), .id_rn_i(id_Rn), .id_rm_i(id_Rm),
    .id_uses_rn_i(id_uses_Rn), .id_uses_rm_i(id_uses_Rm), .load_use_o(load_use)
  );
  always_comb begin
    st_d     = RUN;
    fl_d     = fl_q;
    wt_d     = mem_busy ? (wt_q == 16'(MEM_TIMEOUT) ? wt_q : wt_q + 16'd1) : '0;
    to_d     = to_q;
    ctrl     = CTRL_NORMAL;
    stall_ev = 1'b0;
    br_ev    = 1'b0;
    if (mem_busy) begin
      ctrl = CTRL_FREEZE;
      st_d = st_q == FLUSH ? FLUSH : MEM_WAIT;
      to_d = to_q || ((st_q == MEM_WAIT || st_q == FLUSH) && wt_d == 16'(MEM_TIMEOUT));
    end else if (st_q == FLUSH) begin
      ctrl = CTRL_SQUASH;
      fl_d = fl_q - 4'd1;
      st_d = fl_q == 4'd1 ? RUN : FLUSH;
    end else if (branch_taken) begin
      ctrl  = CTRL_SQUASH;
      fl_d  = 4'(FLUSH_CYCLES);
      st_d  = FLUSH_CYCLES > 0 ? FLUSH : RUN;
      br_ev = 1'b1;
    end else if (load_use) begin
      ctrl     = CTRL_STALL;
      stall_ev = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      st_q <= RUN;
      fl_q <= '0;
      wt_q <= '0;
      to_q <= 1'b0;
    end else begin
      st_q <= st_d;
      fl_q <= fl_d;
      wt_q <= wt_d;
      to_q <= to_d;
    end
  // Reset forces every enable low combinationally, not just at the next edge
  assign {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, ex_mem_write} = rst ? ctrl : '0;
  assign mem_timeout = to_q;
  assign state_o     = st_q;
`ifdef HAZARD_PERF_EN
  logic [31:0] ps_q, pf_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      ps_q <= '0;
      pf_q <= '0;
    end else begin
      ps_q <= ps_q + 32'(stall_ev && ~&ps_q);
      pf_q <= pf_q + 32'(br_ev && ~&pf_q);
    end
  assign perf_stall_cnt = ps_q;
  assign perf_flush_cnt = pf_q;
`endif
endmodule
